// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the WB value, commits it to a 32-entry
// integer register file and counts retired writes. Optional macro: WB_BYPASS_EN.
module wb_regfile #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       NUM_REGS = 32,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_03FC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [DATA_W-1:0] data_ALU_in,
    input  logic [DATA_W-1:0] data_mem_in,
    input  logic [ADDR_W-1:0] Rd_in,
    input  logic [ADDR_W-1:0] Rs1_addr,
    input  logic [ADDR_W-1:0] Rs2_addr,
    output logic [DATA_W-1:0] Rs1_data,
    output logic [DATA_W-1:0] Rs2_data,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [31:0]       retire_count
);

    localparam int unsigned SP_IDX = 2;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              commit_en;

    // Write-back mux and commit qualifier; x0 writes are dropped entirely.
    always_comb begin
        wb_data_out = MemtoReg_in ? data_mem_in : data_ALU_in;
        commit_en   = RegWrite_in && (Rd_in != '0);
    end

    // Array and retire counter; reset takes priority over any commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[ADDR_W'(i)] <= (i == SP_IDX) ? SP_RESET : '0;
            end
            retire_count <= '0;
        end else if (commit_en) begin
            regs[Rd_in]  <= wb_data_out;
            retire_count <= retire_count + 32'd1;
        end
    end

    // Read ports: x0 reads as zero, optional same-cycle forwarding of the commit.
    always_comb begin
        Rs1_data = (Rs1_addr == '0) ? '0 : regs[Rs1_addr];
        Rs2_data = (Rs2_addr == '0) ? '0 : regs[Rs2_addr];
`ifdef WB_BYPASS_EN
        if (commit_en && (Rs1_addr == Rd_in)) Rs1_data = wb_data_out;
        if (commit_en && (Rs2_addr == Rd_in)) Rs2_data = wb_data_out;
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus randomized traffic
// compared every cycle against an array-based model of the register file.
module tb_wb_regfile;

    localparam logic [31:0] SP = 32'h0000_03FC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rw = 1'b0, m2r = 1'b0;
    logic [31:0] alu = '0, mem = '0;
    logic [4:0]  rd = '0, a1 = '0, a2 = '0;
    logic [31:0] rs1_data, rs2_data, wb_data, cnt;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .RegWrite_in(rw), .MemtoReg_in(m2r),
        .data_ALU_in(alu), .data_mem_in(mem), .Rd_in(rd),
        .Rs1_addr(a1), .Rs2_addr(a2),
        .Rs1_data(rs1_data), .Rs2_data(rs2_data),
        .wb_data_out(wb_data), .retire_count(cnt)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    bit          m_valid = 1'b0;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] m_wb();
        return m2r ? mem : alu;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (rw && rd != 5'd0 && a == rd) return m_wb();
`endif
        return m_regs[a];
    endfunction

    // One clock: compare at the falling edge, advance the model, step past the rising edge.
    task automatic cycle();
        @(negedge clk);
        check("wb_data_out", wb_data, m_wb());
        if (m_valid) begin
            check("Rs1_data", rs1_data, m_read(a1));
            check("Rs2_data", rs2_data, m_read(a2));
            check("retire_count", cnt, m_cnt);
        end
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_regs[2] = SP;
            m_cnt     = 32'h0;
            m_valid   = 1'b1;
        end else if (m_valid && rw && rd != 5'd0) begin
            m_regs[rd] = m_wb();
            m_cnt      = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic m, input logic [31:0] al,
                         input logic [31:0] me, input logic [4:0] d,
                         input logic [4:0] r1, input logic [4:0] r2);
        rw = w; m2r = m; alu = al; mem = me; rd = d; a1 = r1; a2 = r2;
    endtask

    initial begin
        // Reset for one edge
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd5);
        cycle();
        rst = 1'b1;
        #1;
        check("reset_x2", rs1_data, 32'h0000_03FC);
        check("reset_x5", rs2_data, 32'h0);
        check("reset_count", cnt, 32'h0);

        // ALU commit to x7
        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd7, 5'd1, 5'd3);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
        #1;
        check("x7_alu", rs1_data, 32'hDEAD_BEEF);
        check("count_1", cnt, 32'd1);

        // Load commit to x8
        drive(1'b1, 1'b1, 32'h0BAD_0BAD, 32'h1234_5678, 5'd8, 5'd0, 5'd0);
        #1;
        check("wb_mux_mem", wb_data, 32'h1234_5678);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd7);
        #1;
        check("x8_mem", rs1_data, 32'h1234_5678);
        check("count_2", cnt, 32'd2);

        // Write to x0 is dropped
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        check("x0_zero", rs1_data, 32'h0);
        check("x0_count", cnt, 32'd2);

        // Read-during-write on x9
        drive(1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0, 5'd9, 5'd0, 5'd9);
        #1;
`ifdef WB_BYPASS_EN
        check("rdw_x9", rs2_data, 32'hA5A5_A5A5);
`else
        check("rdw_x9", rs2_data, 32'h0);
`endif
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9);
        #1;
        check("x9_after", rs2_data, 32'hA5A5_A5A5);

        // Reset beats a simultaneous write to x2
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h1, 32'h0, 5'd2, 5'd2, 5'd7);
        cycle();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd7);
        #1;
        check("rst_vs_wr_x2", rs1_data, 32'h0000_03FC);
        check("rst_vs_wr_x7", rs2_data, 32'h0);
        check("rst_vs_wr_cnt", cnt, 32'h0);

        // Counter wrap
        force dut.retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count;
        m_cnt = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 32'h3333_3333, 32'h0, 5'd3, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        #1;
        check("wrap_count", cnt, 32'h0);
        check("wrap_x3", rs1_data, 32'h3333_3333);

        // Randomized traffic, with occasional resets and read-during-write aliasing
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 63) != 0);
            rw  = ($urandom_range(0, 3) != 0);
            m2r = 1'($urandom_range(0, 1));
            alu = $urandom();
            mem = $urandom();
            rd  = 5'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            cycle();
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
